axis_pkt_rx: RTL and testbench



---
 rtl/axis_pkg.sv | 20 ++
 rtl/axis_rx_result_reg.sv | 47 ++++
 rtl/axis_pkt_rx.sv | 144 ++++++++++++++
 tb/tb_axis_pkt_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and default geometry for the 8-bit, 4-beat AXI4-Stream packet path.
package axis_pkg;

  localparam int AXIS_DATA_W  = 8;
  localparam int AXIS_PKT_LEN = 4;
  localparam int AXIS_SUM_W   = AXIS_DATA_W + $clog2(AXIS_PKT_LEN);
  localparam int AXIS_CNT_W   = $clog2(AXIS_PKT_LEN + 1);

  typedef enum logic {
    ACC   = 1'b0,
    STALL = 1'b1
  } rx_state_t;

  typedef struct packed {
    logic [AXIS_SUM_W-1:0] sum;
    logic [AXIS_CNT_W-1:0] beats;
    logic                  err;
  } rx_rec_t;

endpackage

// File: rtl/axis_rx_result_reg.sv
// One-entry valid/ready holding register for packet result records.
// free_o is high when the entry is empty or draining this cycle, so a new record may load.
module axis_rx_result_reg
  import axis_pkg::*;
#(
  parameter int REC_W = $bits(rx_rec_t)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [REC_W-1:0] load_rec_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [REC_W-1:0] rec_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [REC_W-1:0] rec_q, rec_d;

  assign free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (load_i) begin
      valid_d = 1'b1;
      rec_d   = load_rec_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;

endmodule

// File: rtl/axis_pkt_rx.sv
// AXI4-Stream packet receiver: sums each tlast-framed packet, flags framing errors,
// and emits one record per packet. Optional AXIS_RX_ERR_CNT_EN adds a saturating err_count.
module axis_pkt_rx
  import axis_pkg::*;
#(
  parameter  int DATA_W  = AXIS_DATA_W,
  parameter  int PKT_LEN = AXIS_PKT_LEN,
  localparam int SUM_W   = DATA_W + $clog2(PKT_LEN),
  localparam int CNT_W   = $clog2(PKT_LEN + 1)
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [SUM_W-1:0]  pkt_sum,
  output logic [CNT_W-1:0]  pkt_beats,
  output logic              pkt_err
`ifdef AXIS_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] beats;
    logic             err;
  } rec_t;

  rx_state_t        state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             beat_ok, full, close, close_err;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             load, res_free;
  rec_t             load_rec, out_rec;

  assign s_axis_tready = (state_q == ACC);
  assign beat_ok       = s_axis_tvalid && s_axis_tready;
  assign sum_next      = acc_q + SUM_W'(s_axis_tdata);
  assign cnt_next      = cnt_q + CNT_W'(1);
  assign full          = (cnt_next == CNT_W'(PKT_LEN));
  assign close         = beat_ok && (s_axis_tlast || full);
  // Short packet (tlast early) or long packet (PKT_LEN beats without tlast).
  assign close_err     = s_axis_tlast != full;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    load           = 1'b0;
    load_rec.sum   = sum_next;
    load_rec.beats = cnt_next;
    load_rec.err   = close_err;
    case (state_q)
      ACC: begin
        if (beat_ok) begin
          if (close && res_free) begin
            load  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
          end else begin
            acc_d = sum_next;
            cnt_d = cnt_next;
            if (close) begin
              err_d   = close_err;
              state_d = STALL;
            end
          end
        end
      end
      STALL: begin
        // The accumulator itself holds the closed record until the result slot frees.
        load_rec.sum   = acc_q;
        load_rec.beats = cnt_q;
        load_rec.err   = err_q;
        if (res_free) begin
          load    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ACC;
        end
      end
    endcase
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  axis_rx_result_reg #(
    .REC_W($bits(rec_t))
  ) u_result (
    .clk        (s_axis_aclk),
    .rst        (s_axis_areset),
    .load_i     (load),
    .load_rec_i (load_rec),
    .ready_i    (pkt_ready),
    .valid_o    (pkt_valid),
    .rec_o      (out_rec),
    .free_o     (res_free)
  );

  assign pkt_sum   = out_rec.sum;
  assign pkt_beats = out_rec.beats;
  assign pkt_err   = out_rec.err;

`ifdef AXIS_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load && load_rec.err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) err_cnt_q <= 8'd0;
    else               err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Directed bench for axis_pkt_rx: stimulus pushes expected records, a negedge monitor pops and compares.
module tb_axis_pkt_rx;

  localparam int DATA_W = 8;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 3;
  localparam int REC_W  = SUM_W + CNT_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_axis_tvalid = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              pkt_valid;
  logic              pkt_ready = 1'b0;
  logic [SUM_W-1:0]  pkt_sum;
  logic [CNT_W-1:0]  pkt_beats;
  logic              pkt_err;
`ifdef AXIS_RX_ERR_CNT_EN
  logic [7:0]        err_count;
`endif

  axis_pkt_rx dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_sum       (pkt_sum),
    .pkt_beats     (pkt_beats),
    .pkt_err       (pkt_err)
`ifdef AXIS_RX_ERR_CNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [REC_W-1:0] exp_q[$];
  logic watch_tready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] rec(input int s, input int b, input bit e);
    return {SUM_W'(s), CNT_W'(b), e};
  endfunction

  // Driver: present one beat and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [DATA_W-1:0] d, input logic last);
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    forever begin
      @(negedge clk);
      if (s_axis_tready) break;
      n++;
      if (n >= 100) begin
        tests++;
        fails++;
        $display("FAIL beat_accept_timeout: tready stuck at %0d, expected 1", s_axis_tready);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d records outstanding, expected 0", exp_q.size());
    end
  endtask

  // Scoreboard monitor: compares on every result handshake, checks stability under backpressure.
  logic             held_v = 1'b0;
  logic [REC_W-1:0] held_rec;
  logic [REC_W-1:0] e;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (pkt_valid && held_v) check("hold_stable", {pkt_sum, pkt_beats, pkt_err}, held_rec);
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_record: got sum %0d beats %0d err %0d, expected none",
                   pkt_sum, pkt_beats, pkt_err);
        end else begin
          e = exp_q.pop_front();
          check("rec_sum", pkt_sum, e[REC_W-1 -: SUM_W]);
          check("rec_beats", pkt_beats, e[CNT_W:1]);
          check("rec_err", pkt_err, e[0]);
        end
        held_v = 1'b0;
      end else if (pkt_valid) begin
        held_v   = 1'b1;
        held_rec = {pkt_sum, pkt_beats, pkt_err};
      end else begin
        held_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (watch_tready) check("tready_high", s_axis_tready, 1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tready", s_axis_tready, 1);
    check("rst_valid", pkt_valid, 0);
    check("rst_sum", pkt_sum, 0);
    check("rst_beats", pkt_beats, 0);
    check("rst_err", pkt_err, 0);
`ifdef AXIS_RX_ERR_CNT_EN
    check("rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #1;

    // Nominal packet, latency 1, tready never drops
    pkt_ready = 1'b1;
    exp_q.push_back(rec(30, 4, 0));
    watch_tready = 1'b1;
    send(8'd0, 0); send(8'd5, 0); send(8'd10, 0); send(8'd15, 1);
    @(negedge clk);
    check("nominal_latency", pkt_valid, 1);
    watch_tready = 1'b0;
    drain_wait();

    // Short packet followed by a good one
    exp_q.push_back(rec(16, 2, 1));
    exp_q.push_back(rec(4, 4, 0));
    send(8'd7, 0); send(8'd9, 1);
    send(8'd1, 0); send(8'd1, 0); send(8'd1, 0); send(8'd1, 1);
    drain_wait();

    // Long packet: closes at beat 4, trailing beat is its own short packet
    exp_q.push_back(rec(1020, 4, 1));
    exp_q.push_back(rec(3, 1, 1));
    send(8'd255, 0); send(8'd255, 0); send(8'd255, 0); send(8'd255, 0); send(8'd3, 1);
    drain_wait();
`ifdef AXIS_RX_ERR_CNT_EN
    // Cumulative: one short packet plus the two long-packet records
    check("err_count_after_long", err_count, 3);
`endif

    // Backpressure: second packet stalls in the accumulator
    pkt_ready = 1'b0;
    exp_q.push_back(rec(10, 4, 0));
    exp_q.push_back(rec(8, 4, 0));
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 1);
    send(8'd2, 0); send(8'd2, 0); send(8'd2, 0); send(8'd2, 1);
    repeat (3) begin
      @(negedge clk);
      check("stall_tready_low", s_axis_tready, 0);
      check("stall_sum_held", pkt_sum, 10);
    end
    @(posedge clk);
    #1 pkt_ready = 1'b1;
    @(posedge clk);
    #1 pkt_ready = 1'b0;
    @(negedge clk);
    check("stall_rec2_valid", pkt_valid, 1);
    check("stall_rec2_sum", pkt_sum, 8);
    check("stall_exit_tready", s_axis_tready, 1);
    @(posedge clk);
    #1 pkt_ready = 1'b1;
    drain_wait();

    // Drain and close on the same edge: no stall
    pkt_ready = 1'b0;
    exp_q.push_back(rec(4, 4, 0));
    exp_q.push_back(rec(12, 4, 0));
    send(8'd1, 0); send(8'd1, 0); send(8'd1, 0); send(8'd1, 1);
    watch_tready = 1'b1;
    send(8'd3, 0); send(8'd3, 0); send(8'd3, 0);
    pkt_ready = 1'b1;
    send(8'd3, 1);
    @(negedge clk);
    check("simul_valid", pkt_valid, 1);
    check("simul_sum", pkt_sum, 12);
    watch_tready = 1'b0;
    drain_wait();

    // Async reset with a pending record and a partial packet
    pkt_ready = 1'b0;
    send(8'd9, 0); send(8'd9, 0); send(8'd9, 0); send(8'd9, 1);
    send(8'd5, 0); send(8'd6, 0);
    @(negedge clk);
    check("pre_rst_valid", pkt_valid, 1);
    check("pre_rst_sum", pkt_sum, 36);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tready", s_axis_tready, 1);
    check("async_rst_valid", pkt_valid, 0);
    check("async_rst_sum", pkt_sum, 0);
    check("async_rst_beats", pkt_beats, 0);
    check("async_rst_err", pkt_err, 0);
`ifdef AXIS_RX_ERR_CNT_EN
    check("async_rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    pkt_ready = 1'b1;
    exp_q.push_back(rec(10, 4, 0));
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 1);
    drain_wait();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
